// File: rtl/instruction_memory_sync_pkg.sv
// Shared defaults, NOP encoding and load/run state encoding for the
// synchronous instruction memory.
package instruction_memory_sync_pkg;

  localparam int IMEM_DATA_W = 16;
  localparam int IMEM_ADDR_W = 9;
  localparam int IMEM_DEPTH  = 256;
  localparam logic [15:0] IMEM_NOP = 16'h0000;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } imem_state_t;

  // Unsigned compare at 32 bits so DEPTH == 2**ADDR_W never reports a fault.
  function automatic logic addr_in_range(input logic [31:0] addr, input int depth);
    return (addr < 32'(depth));
  endfunction

endpackage

// File: rtl/instruction_memory_sync_imem_array.sv
// Simple dual-port synchronous RAM: one registered write port and one
// registered read port with read enable. No control logic lives here.
module imem_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rd_data_r;

  // Write port; the caller guarantees wr_addr < DEPTH whenever wr_en is high.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[IDX_W'(wr_addr)] <= wr_data;
    end
  end

  // Read port; data holds its value while rd_en is low.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_r <= mem_r[IDX_W'(rd_addr)];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/instruction_memory_sync.sv
// Boot-loadable instruction store: LOAD/RUN control, range checking and a
// stall-aware registered fetch output around imem_array.
module instruction_memory_sync
  import instruction_memory_sync_pkg::*;
#(
  parameter int                DATA_W   = IMEM_DATA_W,
  parameter int                ADDR_W   = IMEM_ADDR_W,
  parameter int                DEPTH    = IMEM_DEPTH,
  parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(IMEM_NOP)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_done,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              hold,
  output logic              fetch_ready,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic              addr_fault,
  output logic              loaded,
  output logic              load_err
);

  imem_state_t       state_r;
  logic              load_err_r;
  logic              inst_valid_r;
  logic              addr_fault_r;
  logic              nop_sel_r;
  logic              fetch_ready_s;
  logic              load_in_range_s;
  logic              fetch_in_range_s;
  logic              wr_en_s;
  logic              rd_en_s;
  logic [DATA_W-1:0] rd_data_s;
  logic [DATA_W-1:0] inst_s;

  assign load_in_range_s  = addr_in_range(32'(load_addr), DEPTH);
  assign fetch_in_range_s = addr_in_range(32'(fetch_addr), DEPTH);

  // Fetches are only taken in RUN and never while IF is stalled.
  always_comb begin
    fetch_ready_s = 1'b0;
    case (state_r)
      ST_LOAD: fetch_ready_s = 1'b0;
      ST_RUN:  fetch_ready_s = !hold;
      default: fetch_ready_s = 1'b0;
    endcase
  end

  assign wr_en_s = rst_n && (state_r == ST_LOAD) && load_en && load_in_range_s;
  assign rd_en_s = rst_n && fetch_ready_s && fetch_req && fetch_in_range_s;

  imem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_en   (rd_en_s),
    .rd_addr (fetch_addr),
    .rd_data (rd_data_s)
  );

  // Control FSM plus the registered valid/fault/NOP-select flags of the fetch output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_LOAD;
      load_err_r   <= 1'b0;
      inst_valid_r <= 1'b0;
      addr_fault_r <= 1'b0;
      nop_sel_r    <= 1'b1;
    end else begin
      case (state_r)
        ST_LOAD: begin
          if (load_en && !load_in_range_s) begin
            load_err_r <= 1'b1;
          end
          if (load_done) begin
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!hold) begin
            if (fetch_req) begin
              inst_valid_r <= 1'b1;
              addr_fault_r <= !fetch_in_range_s;
              nop_sel_r    <= !fetch_in_range_s;
            end else begin
              inst_valid_r <= 1'b0;
              addr_fault_r <= 1'b0;
            end
          end
        end
        default: state_r <= ST_LOAD;
      endcase
    end
  end

  // The RAM read register is the instruction register; faults and reset select NOP.
  always_comb begin
    inst_s = NOP_INST;
    if (nop_sel_r) begin
      inst_s = NOP_INST;
    end else begin
      inst_s = rd_data_s;
    end
  end

  assign fetch_ready = fetch_ready_s;
  assign inst        = inst_s;
  assign inst_valid  = inst_valid_r;
  assign addr_fault  = addr_fault_r;
  assign loaded      = (state_r == ST_RUN);
  assign load_err    = load_err_r;

endmodule
